csi_rx_phy_seq: RTL and testbench

- Reset sequencer and clock-presence monitor for the CSI-2 RX D-PHY clock lane and byte-lane deserializers.
- Drives the CLR of the regional clock buffers that produce bit_clock/byte_clock, then the deserializer reset, in the required order.
- Watches a toggle derived from byte_clock to confirm the lane clock is running, and re-sequences when the clock is lost or restart is requested.
- Runs on the always-on system clock.

---
 rtl/csi_rx_phy_seq.sv | 176 +++++++++++++++++
 tb/tb_csi_rx_phy_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/csi_rx_phy_seq.sv
`default_nettype none
// ============================================================================
// csi_rx_phy_seq : CSI-2 RX D-PHY reset sequencer and byte-clock presence monitor
// Optional feature macro: CSI_PHY_FREQ_CHECK_EN (adds upper edge-count limit)
// Revision: 1.0
// ============================================================================
module csi_rx_phy_seq #(
  parameter int BUFR_RST_CYC = 16,
  parameter int SETTLE_CYC   = 64,
  parameter int WINDOW_CYC   = 1024,
  parameter int MIN_EDGES    = 32,
  parameter int MAX_EDGES    = 512,
  parameter int LOCK_WINDOWS = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             restart_req,
  input  logic             byte_tgl,
  output logic             phy_reset,
  output logic             serdes_reset,
  output logic             phy_ready,
  output logic             clk_lost,
  output logic [3:0]       retry_cnt,
  output logic [CNT_W-1:0] edge_count
);

  localparam int c_ph_max = (BUFR_RST_CYC > SETTLE_CYC) ? BUFR_RST_CYC : SETTLE_CYC;
  localparam int c_ph_w   = $clog2(c_ph_max + 1);
  localparam int c_win_w  = $clog2(WINDOW_CYC);
  localparam int c_gw_w   = $clog2(LOCK_WINDOWS + 1);

  localparam logic [c_ph_w-1:0]  c_bufr_last   = c_ph_w'(BUFR_RST_CYC - 1);
  localparam logic [c_ph_w-1:0]  c_settle_last = c_ph_w'(SETTLE_CYC - 1);
  localparam logic [c_win_w-1:0] c_win_last    = c_win_w'(WINDOW_CYC - 1);
  localparam logic [c_gw_w-1:0]  c_lock_last   = c_gw_w'(LOCK_WINDOWS - 1);
  localparam logic [CNT_W-1:0]   c_min_edges   = CNT_W'(MIN_EDGES);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_BUFR_RST  = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_LOCK_WAIT = 3'd3,
    ST_RUN       = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;
  logic                r_tgl_s1;
  logic                r_tgl_s2;
  logic                r_tgl_hist;
  logic [c_ph_w-1:0]   r_phase;
  logic [c_win_w-1:0]  r_win;
  logic [CNT_W-1:0]    r_edges;
  logic [c_gw_w-1:0]   r_good;
  logic [CNT_W-1:0]    w_total;
  logic                w_edge;
  logic                w_active;
  logic                w_win_end;
  logic                w_good;
  logic                w_restart;
  logic                w_enter;
  logic                w_lost;

  // byte_tgl is asynchronous here; each transition yields exactly one edge pulse
  assign w_edge    = r_tgl_s2 ^ r_tgl_hist;
  assign w_active  = (r_state == ST_LOCK_WAIT) || (r_state == ST_RUN);
  assign w_win_end = w_active && (r_win == c_win_last);
  assign w_total   = (&r_edges) ? r_edges : (r_edges + CNT_W'(w_edge));

`ifdef CSI_PHY_FREQ_CHECK_EN
  localparam logic [CNT_W-1:0] c_max_edges = CNT_W'(MAX_EDGES);
  assign w_good = (w_total >= c_min_edges) && (w_total <= c_max_edges);
`else
  logic w_unused_max;
  assign w_unused_max = (MAX_EDGES != 0);
  assign w_good       = (w_total >= c_min_edges);
`endif

  assign w_restart = enable && restart_req && (r_state != ST_IDLE);
  assign w_enter   = (w_state_nx != r_state) || w_restart;

  always_comb begin
    w_state_nx = r_state;
    w_lost     = 1'b0;
    if (!enable) begin
      w_state_nx = ST_IDLE;
    end else if (w_restart) begin
      w_state_nx = ST_BUFR_RST;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nx = ST_BUFR_RST;
        end
        ST_BUFR_RST: begin
          if (r_phase == c_bufr_last) w_state_nx = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (r_phase == c_settle_last) w_state_nx = ST_LOCK_WAIT;
        end
        ST_LOCK_WAIT: begin
          if (w_win_end && w_good && (r_good == c_lock_last)) w_state_nx = ST_RUN;
        end
        ST_RUN: begin
          if (w_win_end && !w_good) begin
            w_state_nx = ST_BUFR_RST;
            w_lost     = 1'b1;
          end
        end
        default: begin
          w_state_nx = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_tgl_s1   <= 1'b0;
      r_tgl_s2   <= 1'b0;
      r_tgl_hist <= 1'b0;
      r_phase    <= '0;
      r_win      <= '0;
      r_edges    <= '0;
      r_good     <= '0;
      clk_lost   <= 1'b0;
      retry_cnt  <= 4'd0;
      edge_count <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_tgl_s1   <= byte_tgl;
      r_tgl_s2   <= r_tgl_s1;
      r_tgl_hist <= r_tgl_s2;
      clk_lost   <= w_lost;

      if (w_enter) begin
        r_phase <= '0;
      end else if ((r_state == ST_BUFR_RST) || (r_state == ST_SETTLE)) begin
        r_phase <= r_phase + c_ph_w'(1);
      end else begin
        r_phase <= '0;
      end

      // Window and edge counters sit at zero outside LOCK_WAIT/RUN, so entry starts a fresh window
      if (!w_active || w_win_end) begin
        r_win   <= '0;
        r_edges <= '0;
      end else begin
        r_win   <= r_win + c_win_w'(1);
        r_edges <= w_total;
      end

      if (w_win_end) begin
        edge_count <= w_total;
      end

      if ((r_state != ST_LOCK_WAIT) || (w_state_nx != ST_LOCK_WAIT)) begin
        r_good <= '0;
      end else if (w_win_end) begin
        r_good <= w_good ? (r_good + c_gw_w'(1)) : '0;
      end

      if (w_lost && (retry_cnt != 4'hF)) begin
        retry_cnt <= retry_cnt + 4'd1;
      end
    end
  end

  assign phy_reset    = (r_state == ST_IDLE) || (r_state == ST_BUFR_RST);
  assign serdes_reset = phy_reset || (r_state == ST_SETTLE);
  assign phy_ready    = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_csi_rx_phy_seq.sv
`default_nettype none
// ============================================================================
// tb_csi_rx_phy_seq : directed self-checking bench for csi_rx_phy_seq
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_csi_rx_phy_seq;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic        restart_req;
  logic        byte_tgl;
  logic        phy_reset;
  logic        serdes_reset;
  logic        phy_ready;
  logic        clk_lost;
  logic [3:0]  retry_cnt;
  logic [15:0] edge_count;

  int errors;
  int checks;
  int tgl_period;
  int last_period;
  int tgl_cnt;

  csi_rx_phy_seq #(
    .BUFR_RST_CYC (4),
    .SETTLE_CYC   (8),
    .WINDOW_CYC   (64),
    .MIN_EDGES    (8),
    .MAX_EDGES    (40),
    .LOCK_WINDOWS (2),
    .CNT_W        (16)
  ) u_dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .restart_req  (restart_req),
    .byte_tgl     (byte_tgl),
    .phy_reset    (phy_reset),
    .serdes_reset (serdes_reset),
    .phy_ready    (phy_ready),
    .clk_lost     (clk_lost),
    .retry_cnt    (retry_cnt),
    .edge_count   (edge_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // byte_tgl flips once every tgl_period clocks; 0 stops the lane clock
  initial begin
    byte_tgl    = 1'b0;
    last_period = 0;
    tgl_cnt     = 0;
  end
  always @(posedge clock) begin
    #1;
    if (tgl_period != last_period) begin
      last_period = tgl_period;
      tgl_cnt     = 0;
    end
    if (tgl_period > 0) begin
      tgl_cnt++;
      if (tgl_cnt >= tgl_period) begin
        tgl_cnt  = 0;
        byte_tgl = ~byte_tgl;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Starts at the first BUFR_RST negedge; measures each phase length
  task automatic seq_check(input string tag, input int exp_lock);
    int n;
    n = 0;
    while (phy_reset === 1'b1 && serdes_reset === 1'b1 && n < 100) begin
      n++;
      @(negedge clock);
    end
    chk({tag, "_bufr_cycles"}, n, 4);
    n = 0;
    while (phy_reset === 1'b0 && serdes_reset === 1'b1 && n < 100) begin
      n++;
      @(negedge clock);
    end
    chk({tag, "_settle_cycles"}, n, 8);
    if (exp_lock > 0) begin
      n = 0;
      while (phy_ready !== 1'b1 && phy_reset === 1'b0 && n < 1000) begin
        n++;
        @(negedge clock);
      end
      chk({tag, "_lock_cycles"}, n, exp_lock);
    end
  endtask

  initial begin
    int n;
    logic ever_ready;
    logic ever_lost;
    errors      = 0;
    checks      = 0;
    reset_n     = 1'b0;
    enable      = 1'b1;
    restart_req = 1'b0;
    tgl_period  = 4;

    repeat (3) @(negedge clock);
    chk("rst_phy_reset", phy_reset, 1);
    chk("rst_serdes_reset", serdes_reset, 1);
    chk("rst_phy_ready", phy_ready, 0);
    chk("rst_clk_lost", clk_lost, 0);
    chk("rst_retry_cnt", retry_cnt, 0);
    chk("rst_edge_count", edge_count, 0);

    // Bring-up: 16 edges per window
    reset_n = 1'b1;
    @(negedge clock);
    seq_check("bringup", 128);
    chk("bringup_ready", phy_ready, 1);
    chk("bringup_edge_count", edge_count, 16);
    chk("bringup_retry", retry_cnt, 0);

    // Lane clock lost in RUN
    tgl_period = 0;
    n = 0;
    while (clk_lost !== 1'b1 && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk("lost_latency", n, 64);
    chk("lost_retry", retry_cnt, 1);
    chk("lost_phy_reset", phy_reset, 1);
    chk("lost_phy_ready", phy_ready, 0);
    chk("lost_edges_low", (edge_count < 16'd8), 1);
    tgl_period = 16;
    @(negedge clock);
    chk("lost_pulse_width", clk_lost, 0);

    // Too few edges: never locks
    ever_ready = 1'b0;
    ever_lost  = 1'b0;
    repeat (420) begin
      @(negedge clock);
      if (phy_ready === 1'b1) ever_ready = 1'b1;
      if (clk_lost === 1'b1) ever_lost = 1'b1;
    end
    chk("lockfail_ever_ready", ever_ready, 0);
    chk("lockfail_ever_lost", ever_lost, 0);
    chk("lockfail_retry", retry_cnt, 1);
    chk("lockfail_serdes", serdes_reset, 0);
    chk("lockfail_edge_count", edge_count, 4);

    // Restart from LOCK_WAIT, then again during SETTLE
    restart_req = 1'b1;
    @(negedge clock);
    restart_req = 1'b0;
    n = 0;
    while (phy_reset === 1'b1 && n < 100) begin
      n++;
      @(negedge clock);
    end
    chk("restart_lw_bufr", n, 4);
    @(negedge clock);
    @(negedge clock);
    chk("settle_phy_reset", phy_reset, 0);
    chk("settle_serdes", serdes_reset, 1);
    restart_req = 1'b1;
    tgl_period  = 4;
    @(negedge clock);
    restart_req = 1'b0;
    chk("restart_settle_lost", clk_lost, 0);
    chk("restart_settle_retry", retry_cnt, 1);
    seq_check("restart_settle", 128);
    chk("relock_edge_count", edge_count, 16);

    // Restart in RUN
    restart_req = 1'b1;
    @(negedge clock);
    restart_req = 1'b0;
    chk("restart_run_ready", phy_ready, 0);
    chk("restart_run_phy_reset", phy_reset, 1);
    chk("restart_run_lost", clk_lost, 0);
    chk("restart_run_retry", retry_cnt, 1);
    seq_check("restart_run", 0);

    // enable low mid-LOCK_WAIT
    repeat (20) @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    chk("disable_phy_reset", phy_reset, 1);
    chk("disable_serdes", serdes_reset, 1);
    chk("disable_ready", phy_ready, 0);
    repeat (3) @(negedge clock);
    chk("idle_hold", phy_reset, 1);
    enable = 1'b1;
    @(negedge clock);
    seq_check("reenable", 128);
    chk("reenable_retry", retry_cnt, 1);

    // Asynchronous reset while in RUN
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_phy_reset", phy_reset, 1);
    chk("async_serdes", serdes_reset, 1);
    chk("async_ready", phy_ready, 0);
    chk("async_retry", retry_cnt, 0);
    chk("async_edge_count", edge_count, 0);

    // Edge every cycle: 64 edges per window
    tgl_period = 1;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
`ifdef CSI_PHY_FREQ_CHECK_EN
    seq_check("fast", 0);
    ever_ready = 1'b0;
    repeat (300) begin
      @(negedge clock);
      if (phy_ready === 1'b1) ever_ready = 1'b1;
    end
    chk("fast_ever_ready", ever_ready, 0);
    chk("fast_serdes", serdes_reset, 0);
`else
    seq_check("fast", 128);
    chk("fast_ready", phy_ready, 1);
`endif
    chk("fast_edge_count", edge_count, 64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
